rr_slot_arbiter: RTL and testbench
==================================

// Module: rr_slot_arbiter
// PURPOSE
//  Round-robin arbiter for one shared resource (e.g. a sequencer slot).
//  Up to N_REQ requesters use a level req/grant handshake.
//  Ownership is held until the owner drops req, optionally bounded by a hold timeout.
//  A one-cycle dead gap separates consecutive owners. Sits between the requesters
//  and the shared resource; idle_o flags the unowned state.
// PARAMETERS
//  N_REQ    3  number of requesters (>=2, need not be a power of 2)
//  MAX_HOLD 8  max cycles in GRANT before forced release (MAX_HOLD_EN only, >=1)
// PORTS
//  clk        in  1                clock, rising edge
//  reset      in  1                asynchronous, active-high
//  req_i      in  N_REQ            level request, one bit per requester
//  grant_o    out N_REQ            registered one-hot grant (all-zero when none)
//  grant_id_o out $clog2(N_REQ)    index of current owner (0 when none)
//  idle_o     out 1                1 in IDLE state
//  timeout_o  out 1                1-cycle pulse on forced release
// BEHAVIOUR
//  - Reset (async): state=IDLE, grant_o=0, grant_id_o=0, idle_o=1, timeout_o=0, ptr=0.
//    Takes effect immediately, including mid-grant.
//  - States (rr_arb_pkg::state_t): IDLE, GRANT, GAP.
//  - Pick: first i with req_i[i]=1, scanning ptr, ptr+1, ... with modulo N_REQ wrap.
//  - IDLE: if |req_i, go to GRANT with grant_o=onehot(pick) at the next edge
//    (1-cycle latency). Otherwise stay in IDLE.
//  - GRANT: hold the owner while req_i[owner]=1. Requests from other requesters are ignored.
//  - Release: req_i[owner]=0 sampled -> next edge: GAP, grant_o=0, ptr=(owner+1)%N_REQ.
//    Wrap: N_REQ-1 -> 0.
//  - GAP: exactly one cycle, grant_o=0. If |req_i, go to GRANT with a new pick using
//    the updated ptr; else go to IDLE.
//  - Pick is combinational from registered ptr and live req_i. Grant only changes at edges.
//  - A req that drops before being granted is simply not picked. No request queueing.
// CONFIGURATION
//  `define MAX_HOLD_EN:
//  - A hold counter clears on entering GRANT and increments every GRANT cycle.
//  - At cnt==MAX_HOLD-1 with req still high, the next edge forces release: GAP,
//    ptr advances as normal, timeout_o=1 for that GAP cycle only.
//  - If release and timeout coincide, it is a normal release: timeout_o stays 0.
//  - A timed-out owner stays eligible but is placed last in round-robin order.
//  Without the macro: no counter logic, timeout_o tied to 0, hold time unbounded.
// STRUCTURE
//  - Package rr_arb_pkg: typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t.
//    Also holds the width helper function idx_w(n)=$clog2(n).
//  - Sub-module rr_pick: combinational rotate-priority encoder.
//    Inputs req, ptr. Outputs valid, idx.
//  - The top level holds the FSM, ptr, owner/grant registers and the optional counter.
// TESTING (N_REQ=3, MAX_HOLD=8 unless stated)
//  1. Reset held, random req_i -> grant_o=000, grant_id_o=0, idle_o=1, timeout_o=0.
//  2. req_i=010 at cycle 0 -> grant_o=010, grant_id_o=1 at edge 1.
//     Drop at cycle 4 -> grant_o=000 at edge 5 (GAP), idle_o=1 at edge 6.
//  3. req_i=111 from reset; each owner drops req for 1 cycle after a 2-cycle grant,
//     then re-raises -> grant order 0,1,2,0,1, with one 000 cycle between owners.
//  4. Wrap: ptr=2, req_i=101 -> grant 2 first.
//     After its release, req_i=101 -> grant 0 (not 2).
//  5. MAX_HOLD_EN: req_i=011 held for 30 cycles.
//     -> grant0 for exactly 8 cycles, GAP with timeout_o=1, then grant1 for 8 cycles.
//     Without the macro: grant0 for all 30 cycles, timeout_o=0.
//  6. Reset asserted mid-cycle while grant_o=100 -> grant_o=000 and idle_o=1 immediately.
//     After deassert with req_i=100 -> grant0 one edge later (ptr back to 0).

Source files
------------

// File: rtl/rr_slot_arbiter_pkg.sv
// Shared types and helpers for the round-robin slot arbiter (rr_slot_arbiter).
package rr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rr_slot_arbiter_pick.sv
// Rotate-priority encoder: first asserted request at or after ptr, wrapping modulo N.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]          req,
    input  logic [idx_w(N)-1:0]   ptr,
    output logic                  valid,
    output logic [idx_w(N)-1:0]   idx
);

    localparam int W = idx_w(N);

    logic [2*N-1:0]      dbl;
    logic [N-1:0]        rot;
    logic [N-1:0]        first;
    logic [N:0][W-1:0]   off_chain;
    logic [W:0]          sum;

    // Rotating a doubled copy puts the requester at ptr in bit 0 of rot.
    assign dbl = {req, req};
    assign rot = N'(dbl >> ptr);

    assign off_chain[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_first
            if (gi == 0) begin : g_lsb
                assign first[gi] = rot[gi];
            end else begin : g_upper
                assign first[gi] = rot[gi] & ~(|rot[gi-1:0]);
            end
            assign off_chain[gi+1] = off_chain[gi] | (first[gi] ? W'(gi) : '0);
        end
    endgenerate

    assign sum   = {1'b0, ptr} + {1'b0, off_chain[N]};
    assign idx   = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
    assign valid = |req;

endmodule

// File: rtl/rr_slot_arbiter.sv
// Round-robin owner arbiter with one-cycle dead gap between owners.
// Define MAX_HOLD_EN to bound ownership to MAX_HOLD cycles with a timeout pulse.
module rr_slot_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int MAX_HOLD = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_i,
    output logic [N_REQ-1:0]          grant_o,
    output logic [idx_w(N_REQ)-1:0]   grant_id_o,
    output logic                      idle_o,
    output logic                      timeout_o
);

    localparam int W = idx_w(N_REQ);

    state_t             state_q, state_d;
    logic [W-1:0]       ptr_q, ptr_d;
    logic [W-1:0]       owner_q, owner_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               timeout_q, timeout_d;
    logic               pick_valid;
    logic [W-1:0]       pick_idx;
    logic               hold_expired;

    rr_pick #(.N(N_REQ)) u_pick (
        .req   (req_i),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

`ifdef MAX_HOLD_EN
    localparam int CNT_W = idx_w(MAX_HOLD) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter reads 0 in the first GRANT cycle, so MAX_HOLD-1 marks the last allowed one.
    assign cnt_d        = (state_q == GRANT) ? cnt_q + CNT_W'(1) : '0;
    assign hold_expired = (state_q == GRANT) && (cnt_q == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign hold_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                if (pick_valid) begin
                    state_d = GRANT;
                    owner_d = pick_idx;
                end else begin
                    state_d = IDLE;
                    owner_d = '0;
                end
            end
            GRANT: begin
                if (!req_i[owner_q] || hold_expired) begin
                    state_d   = GAP;
                    owner_d   = '0;
                    ptr_d     = (owner_q == W'(N_REQ - 1)) ? '0 : owner_q + W'(1);
                    // A voluntary drop on the final allowed cycle is not a timeout.
                    timeout_d = req_i[owner_q];
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = '0;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_grant
            assign grant_d[gi] = (state_d == GRANT) && (owner_d == W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            grant_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant_o    = grant_q;
    assign grant_id_o = owner_q;
    assign idle_o     = (state_q == IDLE);
    assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_rr_slot_arbiter.sv
// Scoreboard bench for rr_slot_arbiter: directed scenarios plus random traffic vs. a reference model.
module tb_rr_slot_arbiter;

    localparam int N    = 3;
    localparam int MAXH = 8;
    localparam int W    = $clog2(N);

    logic           clk   = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_i = '0;
    logic [N-1:0]   grant_o;
    logic [W-1:0]   grant_id_o;
    logic           idle_o;
    logic           timeout_o;

    rr_slot_arbiter #(.N_REQ(N), .MAX_HOLD(MAXH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_i      (req_i),
        .grant_o    (grant_o),
        .grant_id_o (grant_id_o),
        .idle_o     (idle_o),
        .timeout_o  (timeout_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [N-1:0] g;
        int           id;
        bit           idle;
        bit           to;
    } exp_t;

    exp_t sb[$];

`ifdef MAX_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    // Reference model: phase 0 = unowned, 1 = owned, 2 = dead gap after an owner.
    int m_phase = 0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_to    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int m_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    task automatic model_step(input logic [N-1:0] r, input bit rst);
        if (rst) begin
            m_phase = 0;
            m_owner = 0;
            m_ptr   = 0;
            m_held  = 0;
            m_to    = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_phase == 1) begin
                if (!r[m_owner]) begin
                    m_phase = 2;
                    m_ptr   = (m_owner + 1) % N;
                end else if (HOLD_EN && m_held >= MAXH) begin
                    m_phase = 2;
                    m_ptr   = (m_owner + 1) % N;
                    m_to    = 1'b1;
                end else begin
                    m_held++;
                end
            end else if (r != '0) begin
                m_owner = m_pick(r, m_ptr);
                m_phase = 1;
                m_held  = 1;
            end else begin
                m_phase = 0;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.g    = (m_phase == 1) ? N'(1 << m_owner) : '0;
        e.id   = (m_phase == 1) ? m_owner : 0;
        e.idle = (m_phase == 0);
        e.to   = m_to;
        return e;
    endfunction

    // Drive one cycle of inputs at the falling edge and queue the response due after the next rising edge.
    task automatic step(input logic [N-1:0] r, input bit rst);
        @(negedge clk);
        req_i = r;
        reset = rst;
        model_step(r, rst);
        sb.push_back(model_out());
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        int   txn;
        txn = 0;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                txn++;
                $display("txn %0d req=%b rst=%0b grant=%b id=%0d idle=%0b to=%0b", txn, req_i, reset,
                         grant_o, grant_id_o, idle_o, timeout_o);
                check("sb_grant", 32'(grant_o), 32'(e.g));
                check("sb_grant_id", 32'(grant_id_o), 32'(e.id));
                check("sb_idle", 32'(idle_o), 32'(e.idle));
                check("sb_timeout", 32'(timeout_o), 32'(e.to));
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int           seq[$];
        int           exp_order[5];
        logic [N-1:0] prev_g;
        logic [N-1:0] r3;
        logic [N-1:0] rr;

        exp_order = '{0, 1, 2, 0, 1};

        // Reset held with random requests.
        repeat (5) step(N'($urandom_range(0, 7)), 1'b1);
        after_edge();
        check("rst_grant", 32'(grant_o), 32'(0));
        check("rst_idle", 32'(idle_o), 32'(1));

        // Single requester: 1-cycle latency, gap, then idle.
        step('0, 1'b0);
        step('0, 1'b0);
        step(3'b010, 1'b0);
        after_edge();
        check("t2_grant_edge1", 32'(grant_o), 32'(3'b010));
        check("t2_id_edge1", 32'(grant_id_o), 32'(1));
        repeat (3) step(3'b010, 1'b0);
        step(3'b000, 1'b0);
        after_edge();
        check("t2_gap_grant", 32'(grant_o), 32'(0));
        check("t2_gap_not_idle", 32'(idle_o), 32'(0));
        step(3'b000, 1'b0);
        after_edge();
        check("t2_idle_edge6", 32'(idle_o), 32'(1));

        // All requesting, each owner drops for one cycle after two grant cycles.
        step('0, 1'b1);
        prev_g = '0;
        for (int c = 0; c < 30 && seq.size() < 5; c++) begin
            r3 = 3'b111;
            if (m_phase == 1 && m_held == 2) r3[m_owner] = 1'b0;
            step(r3, 1'b0);
            after_edge();
            if (grant_o != '0 && prev_g == '0) seq.push_back(int'(grant_id_o));
            if (prev_g != '0 && grant_o != prev_g) check("t3_gap_between_owners", 32'(grant_o), 32'(0));
            prev_g = grant_o;
        end
        check("t3_grant_count", 32'(seq.size()), 32'(5));
        for (int k = 0; k < seq.size() && k < 5; k++) begin
            check("t3_grant_order", 32'(seq[k]), 32'(exp_order[k]));
        end

        // Pointer wrap: ptr=2 then ptr=0.
        step('0, 1'b1);
        step(3'b010, 1'b0);
        step(3'b010, 1'b0);
        step(3'b000, 1'b0);
        step(3'b000, 1'b0);
        step(3'b101, 1'b0);
        after_edge();
        check("t4_wrap_first", 32'(grant_o), 32'(3'b100));
        step(3'b101, 1'b0);
        step(3'b001, 1'b0);
        step(3'b101, 1'b0);
        after_edge();
        check("t4_wrap_second", 32'(grant_o), 32'(3'b001));

        // Two requesters held continuously.
        step('0, 1'b1);
        for (int i = 1; i <= 30; i++) begin
            step(3'b011, 1'b0);
            after_edge();
`ifdef MAX_HOLD_EN
            if (i == 8)  check("t5_last_owner0", 32'(grant_o), 32'(3'b001));
            if (i == 9)  check("t5_gap_grant", 32'(grant_o), 32'(0));
            if (i == 9)  check("t5_timeout_pulse", 32'(timeout_o), 32'(1));
            if (i == 10) check("t5_owner1", 32'(grant_o), 32'(3'b010));
            if (i == 10) check("t5_pulse_ends", 32'(timeout_o), 32'(0));
            if (i == 17) check("t5_last_owner1", 32'(grant_o), 32'(3'b010));
            if (i == 18) check("t5_second_timeout", 32'(timeout_o), 32'(1));
`else
            check("t5_hold_owner0", 32'(grant_o), 32'(3'b001));
            check("t5_no_timeout", 32'(timeout_o), 32'(0));
`endif
        end

        // Asynchronous reset mid-grant, pointer restored to 0.
        step('0, 1'b1);
        step(3'b001, 1'b0);
        step(3'b001, 1'b0);
        step(3'b000, 1'b0);
        step(3'b000, 1'b0);
        step(3'b100, 1'b0);
        step(3'b100, 1'b0);
        @(posedge clk);
        #3;
        check("t6_granted_before_reset", 32'(grant_o), 32'(3'b100));
        reset = 1'b1;
        #1;
        check("t6_async_grant", 32'(grant_o), 32'(0));
        check("t6_async_idle", 32'(idle_o), 32'(1));
        check("t6_async_id", 32'(grant_id_o), 32'(0));
        model_step(3'b100, 1'b1);
        step(3'b100, 1'b1);
        step(3'b101, 1'b0);
        after_edge();
        check("t6_ptr_reset", 32'(grant_o), 32'(3'b001));

        // Random traffic with occasional resets.
        rr = '0;
        repeat (400) begin
            rr = rr ^ (N'($urandom) & N'($urandom) & N'($urandom));
            step(rr, ($urandom_range(0, 63) == 0));
        end

        @(posedge clk);
        #3;
        check("sb_drained", 32'(sb.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
